// File: rtl/keypad_if.sv
// Key interface between the 4x4 keypad scanner (master) and its consumer / keypad pins (slave).
interface keypad_if;
   logic [3:0] fil;
   logic [3:0] col;
   logic [3:0] key_hex;
   logic       key_valid;
   logic       key_held;

   modport master (input fil, output col, key_hex, key_valid, key_held);
   modport slave  (output fil, input col, key_hex, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, 2-flop row sync, debounce, hex decode, valid strobe.
// Optional auto-repeat of key_valid while held is enabled with `define KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int SCAN_CYCLES   = 1000,
   parameter int DEBOUNCE_CNT  = 8,
   parameter int REPEAT_DWELLS = 250
) (
   input  logic     clk,
   input  logic     rst,
   keypad_if.master kp
);
   localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam int RW = $clog2(REPEAT_DWELLS + 1);

   if (SCAN_CYCLES < 4 || DEBOUNCE_CNT < 1 || REPEAT_DWELLS < 1) begin : g_param_check
      $error("keypad_scanner: illegal parameter value");
   end

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

   state_t          r_state, w_state_nxt;
   logic [3:0]      r_sync1, r_fil_s;
   logic [DW-1:0]   r_dwell;
   logic [1:0]      r_idx, w_idx_nxt;
   logic [1:0]      r_row, w_row_nxt;
   logic [CW-1:0]   r_deb, w_deb_nxt;
   logic [CW-1:0]   r_rel, w_rel_nxt;
   logic [3:0]      r_hex, w_hex_nxt;
   logic            r_valid, w_valid_nxt;
   logic            r_held, w_held_nxt;
   logic            w_sample, w_one_low, w_row_match, w_accept;
   logic [1:0]      w_low_row, w_acc_row;
`ifdef KEYPAD_REPEAT_EN
   logic [RW-1:0]   r_rep, w_rep_nxt;
`endif

   function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'b0000: decode = 4'h1;
         4'b0001: decode = 4'h2;
         4'b0010: decode = 4'h3;
         4'b0011: decode = 4'hA;
         4'b0100: decode = 4'h4;
         4'b0101: decode = 4'h5;
         4'b0110: decode = 4'h6;
         4'b0111: decode = 4'hB;
         4'b1000: decode = 4'h7;
         4'b1001: decode = 4'h8;
         4'b1010: decode = 4'h9;
         4'b1011: decode = 4'hC;
         4'b1100: decode = 4'hE;
         4'b1101: decode = 4'h0;
         4'b1110: decode = 4'hF;
         default: decode = 4'hD;
      endcase
   endfunction

   assign w_sample    = (r_dwell == DW'(SCAN_CYCLES - 1));
   assign w_row_match = (r_fil_s == ~(4'b0001 << r_row));

   // Exactly one row low is the only pattern treated as a key; ghosting patterns fall through.
   always_comb begin
      w_one_low = 1'b1;
      w_low_row = 2'd0;
      case (r_fil_s)
         4'b1110: w_low_row = 2'd0;
         4'b1101: w_low_row = 2'd1;
         4'b1011: w_low_row = 2'd2;
         4'b0111: w_low_row = 2'd3;
         default: w_one_low = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_row_nxt   = r_row;
      w_deb_nxt   = r_deb;
      w_rel_nxt   = r_rel;
      w_hex_nxt   = r_hex;
      w_valid_nxt = 1'b0;
      w_held_nxt  = r_held;
      w_accept    = 1'b0;
      w_acc_row   = r_row;
`ifdef KEYPAD_REPEAT_EN
      w_rep_nxt   = r_rep;
`endif
      if (w_sample) begin
         unique case (r_state)
            SCAN: begin
               if (w_one_low) begin
                  w_row_nxt = w_low_row;
                  w_deb_nxt = CW'(1);
                  if (DEBOUNCE_CNT == 1) begin
                     w_accept  = 1'b1;
                     w_acc_row = w_low_row;
                  end else begin
                     w_state_nxt = DEBOUNCE;
                  end
               end else begin
                  w_idx_nxt = r_idx + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (w_row_match) begin
                  w_deb_nxt = r_deb + CW'(1);
                  if (r_deb + CW'(1) == CW'(DEBOUNCE_CNT)) w_accept = 1'b1;
               end else begin
                  w_idx_nxt   = r_idx + 2'd1;
                  w_state_nxt = SCAN;
               end
            end
            PRESSED: begin
               if (r_fil_s == 4'hF) begin
                  w_rel_nxt = r_rel + CW'(1);
                  if (r_rel + CW'(1) == CW'(DEBOUNCE_CNT)) begin
                     w_held_nxt  = 1'b0;
                     w_idx_nxt   = r_idx + 2'd1;
                     w_state_nxt = SCAN;
                  end
               end else begin
                  w_rel_nxt = '0;
               end
`ifdef KEYPAD_REPEAT_EN
               if (w_row_match) begin
                  if (r_rep + RW'(1) == RW'(REPEAT_DWELLS)) begin
                     w_valid_nxt = 1'b1;
                     w_rep_nxt   = '0;
                  end else begin
                     w_rep_nxt = r_rep + RW'(1);
                  end
               end else begin
                  w_rep_nxt = '0;
               end
`endif
            end
            default: w_state_nxt = SCAN;
         endcase
      end
      if (w_accept) begin
         w_hex_nxt   = decode(w_acc_row, r_idx);
         w_valid_nxt = 1'b1;
         w_held_nxt  = 1'b1;
         w_rel_nxt   = '0;
         w_state_nxt = PRESSED;
`ifdef KEYPAD_REPEAT_EN
         w_rep_nxt   = '0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= SCAN;
         r_sync1 <= 4'hF;
         r_fil_s <= 4'hF;
         r_dwell <= '0;
         r_idx   <= 2'd0;
         r_row   <= 2'd0;
         r_deb   <= '0;
         r_rel   <= '0;
         r_hex   <= 4'h0;
         r_valid <= 1'b0;
         r_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         r_rep   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_sync1 <= kp.fil;
         r_fil_s <= r_sync1;
         r_dwell <= w_sample ? '0 : r_dwell + DW'(1);
         r_idx   <= w_idx_nxt;
         r_row   <= w_row_nxt;
         r_deb   <= w_deb_nxt;
         r_rel   <= w_rel_nxt;
         r_hex   <= w_hex_nxt;
         r_valid <= w_valid_nxt;
         r_held  <= w_held_nxt;
`ifdef KEYPAD_REPEAT_EN
         r_rep   <= w_rep_nxt;
`endif
      end
   end

   assign kp.col       = ~(4'b0001 << r_idx);
   assign kp.key_hex   = r_hex;
   assign kp.key_valid = r_valid;
   assign kp.key_held  = r_held;
endmodule
